// File: rtl/pattern_pkg.sv
// Shared definitions for the framebuffer pattern generators.
// Holds the pattern mode encodings, the fill FSM state type and a
// helper that derives the per-channel colour width from the pixel width.
package pattern_pkg;

  // Pattern mode encodings as seen on the mode inputs
  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_LINES = 3'd3;

  // Fill sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  // A pixel is packed as {R, G, B}, each channel a third of the pixel width
  function automatic int chanWidth(input int dataWidth);
    return dataWidth / 3;
  endfunction

endpackage

// File: rtl/pattern_color.sv
// Combinational pattern colour generator.
// Maps (mode, x, y, base colour) to one pixel value. Kept free of state so
// other pattern blocks can reuse it.
//
// Ports:
//   mode_i   2           pattern mode (see pattern_pkg)
//   x_i      XW          pixel column
//   y_i      YW          pixel line
//   color_i  DATA_WIDTH  base colour for solid and checkerboard modes
//   pixel_o  DATA_WIDTH  resulting pixel
module pattern_color
  import pattern_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int XW         = 9,
  parameter int YW         = 8,
  parameter int CHECK_LOG2 = 3
) (
  input  logic [1:0]            mode_i,
  input  logic [XW-1:0]         x_i,
  input  logic [YW-1:0]         y_i,
  input  logic [DATA_WIDTH-1:0] color_i,
  output logic [DATA_WIDTH-1:0] pixel_o
);

  localparam int CW  = chanWidth(DATA_WIDTH);
  localparam int EW0 = (XW > YW) ? XW : YW;
  localparam int EW1 = (EW0 > CW) ? EW0 : CW;
  localparam int EW  = (EW1 > CHECK_LOG2) ? EW1 : CHECK_LOG2 + 1;

  // Coordinates are zero-extended so narrow counters still fill a channel
  // and always have a checkerboard bit to select.
  logic [EW-1:0] xExt;
  logic [EW-1:0] yExt;
  logic          checkOdd;
  logic          unusedBits;

  assign xExt       = EW'(x_i);
  assign yExt       = EW'(y_i);
  assign checkOdd   = xExt[CHECK_LOG2] ^ yExt[CHECK_LOG2];
  assign unusedBits = ^{xExt, yExt};

  // Select the pixel for the requested pattern; solid is the fallback
  always_comb begin
    pixel_o = color_i;
    case (mode_i)
      MODE_SOLID: pixel_o = color_i;
      MODE_GRAD:  pixel_o = {3{xExt[CW-1:0]}};
      MODE_CHECK: pixel_o = checkOdd ? ~color_i : color_i;
      MODE_LINES: pixel_o = {3{yExt[CW-1:0]}};
      default:    pixel_o = color_i;
    endcase
  end

endmodule

// File: rtl/pattern_fill_gen.sv
// Framebuffer pattern fill generator.
// Writes one COLUMNS x LINES frame into a framebuffer write port, one pixel
// per write slot, slots spaced SPEED+1 cycles apart. Can repeat frames.
//
// Ports:
//   clk           system clock
//   i_reset       synchronous active-high reset
//   i_start       start request, honoured only when idle
//   i_mode        pattern mode, latched at each frame start
//   i_color       base colour, latched at each frame start
//   i_continuous  repeat frames; sampled at the end of each frame
//   o_addr        framebuffer write address
//   o_data        framebuffer write data
//   o_write       write strobe, one cycle per pixel
//   o_busy        frame in progress
//   o_frame_done  pulse alongside the last pixel write
module pattern_fill_gen
  import pattern_pkg::*;
#(
  parameter int COLUMNS    = 320,
  parameter int LINES      = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12,
  parameter int SPEED      = 0,
  parameter int CHECK_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [1:0]            i_mode,
  input  logic [DATA_WIDTH-1:0] i_color,
  input  logic                  i_continuous,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_write,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int XW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
  localparam int YW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int PW = (SPEED > 0) ? $clog2(SPEED + 1) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(COLUMNS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(LINES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SPEED);

  fill_state_e           state_q, state_d;
  logic [XW-1:0]         xCnt_q, xCnt_d;
  logic [YW-1:0]         yCnt_q, yCnt_d;
  logic [ADDR_WIDTH-1:0] pixAddr_q, pixAddr_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  issue;
  logic                  firstPix;
  logic                  lastPix;
  logic [1:0]            patMode;
  logic [DATA_WIDTH-1:0] patColor;
  logic [DATA_WIDTH-1:0] pixel;

  // Counters sit at zero whenever a new frame is about to begin (idle, or
  // just wrapped), so pixel 0 takes its mode/colour straight from the inputs
  // and latches them for the rest of the frame.
  assign firstPix = (xCnt_q == '0) && (yCnt_q == '0);
  assign lastPix  = (xCnt_q == X_LAST) && (yCnt_q == Y_LAST);
  assign patMode  = firstPix ? i_mode : mode_q;
  assign patColor = firstPix ? i_color : color_q;

  pattern_color #(
    .DATA_WIDTH (DATA_WIDTH),
    .XW         (XW),
    .YW         (YW),
    .CHECK_LOG2 (CHECK_LOG2)
  ) u_color (
    .mode_i  (patMode),
    .x_i     (xCnt_q),
    .y_i     (yCnt_q),
    .color_i (patColor),
    .pixel_o (pixel)
  );

  // Next-state logic: decide whether this edge issues a pixel write, then
  // advance the scan counters and register the write outputs.
  always_comb begin
    state_d   = state_q;
    xCnt_d    = xCnt_q;
    yCnt_d    = yCnt_q;
    pixAddr_d = pixAddr_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    color_d   = color_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    issue     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (i_start) begin
          state_d = ST_FILL;
          busy_d  = 1'b1;
          issue   = 1'b1;
        end
      end
      ST_FILL: begin
        busy_d = 1'b1;
        // The cycle after the last pixel decides whether the run goes on
        if (done_q && !i_continuous) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (presc_q == P_LAST) begin
          issue = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      write_d = 1'b1;
      addr_d  = pixAddr_q;
      data_d  = pixel;
      presc_d = '0;
      if (firstPix) begin
        mode_d  = i_mode;
        color_d = i_color;
      end
      if (lastPix) begin
        done_d    = 1'b1;
        xCnt_d    = '0;
        yCnt_d    = '0;
        pixAddr_d = '0;
      end else begin
        pixAddr_d = pixAddr_q + ADDR_WIDTH'(1);
        if (xCnt_q == X_LAST) begin
          xCnt_d = '0;
          yCnt_d = yCnt_q + YW'(1);
        end else begin
          xCnt_d = xCnt_q + XW'(1);
        end
      end
    end
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      xCnt_q    <= '0;
      yCnt_q    <= '0;
      pixAddr_q <= '0;
      presc_q   <= '0;
      mode_q    <= '0;
      color_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xCnt_q    <= xCnt_d;
      yCnt_q    <= yCnt_d;
      pixAddr_q <= pixAddr_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_addr       = addr_q;
  assign o_data       = data_q;
  assign o_write      = write_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_pattern_fill_gen.sv
// Testbench for pattern_fill_gen on a 4x3 frame.
// Instance A runs with no write spacing, instance B with two idle cycles
// between writes. Expected writes (address, data, frame-done flag and the
// cycle they must appear in) are queued when a frame is started; monitors
// pop and compare them whenever a DUT strobes a write.
module tb_pattern_fill_gen;

  localparam int COLS  = 4;
  localparam int LNS   = 3;
  localparam int AW    = 4;
  localparam int DW    = 12;
  localparam int CL    = 1;
  localparam int NPIX  = COLS * LNS;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [DW-1:0] color;
  logic          cont;
  logic          aStart;
  logic          bStart;

  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aData, bData;
  logic          aWrite, bWrite, aBusy, bBusy, aDone, bDone;

  typedef struct {
    int            addr;
    logic [DW-1:0] data;
    logic          done;
    int            cyc;
  } exp_t;

  exp_t qA[$];
  exp_t qB[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [AW-1:0] bLastAddr;
  logic [DW-1:0] bLastData;
  logic          bHaveLast = 1'b0;

  pattern_fill_gen #(
    .COLUMNS(COLS), .LINES(LNS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SPEED(0), .CHECK_LOG2(CL)
  ) dutA (
    .clk(clock), .i_reset(reset), .i_start(aStart), .i_mode(mode),
    .i_color(color), .i_continuous(cont), .o_addr(aAddr), .o_data(aData),
    .o_write(aWrite), .o_busy(aBusy), .o_frame_done(aDone)
  );

  pattern_fill_gen #(
    .COLUMNS(COLS), .LINES(LNS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SPEED(2), .CHECK_LOG2(CL)
  ) dutB (
    .clk(clock), .i_reset(reset), .i_start(bStart), .i_mode(mode),
    .i_color(color), .i_continuous(cont), .o_addr(bAddr), .o_data(bData),
    .o_write(bWrite), .o_busy(bBusy), .o_frame_done(bDone)
  );

  always #5 clock = ~clock;

  // Cycle counter used to timestamp every write
  always @(posedge clock) cyc <= cyc + 1;

  // Reference pattern for a 4-bit channel and a 2-pixel checker square
  function automatic logic [DW-1:0] expPix(input logic [1:0] m, input logic [DW-1:0] c,
                                           input int x, input int y);
    logic [3:0] xv;
    logic [3:0] yv;
    xv = x[3:0];
    yv = y[3:0];
    case (m)
      2'd0:    return c;
      2'd1:    return {xv, xv, xv};
      2'd2:    return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? ~c : c;
      default: return {yv, yv, yv};
    endcase
  endfunction

  // Monitor for instance A: every write must match the head of its queue
  always @(negedge clock) begin
    if (aWrite) begin
      checks++;
      if (qA.size() == 0) begin
        errors++;
        $display("[TB] FAIL writeA: unexpected write addr=%0d data=%h cycle=%0d, required no write",
                 aAddr, aData, cyc);
      end else begin
        exp_t e;
        e = qA.pop_front();
        if (int'(aAddr) != e.addr || aData !== e.data || aDone !== e.done || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL writeA: got addr=%0d data=%h done=%b cycle=%0d, required addr=%0d data=%h done=%b cycle=%0d",
                   aAddr, aData, aDone, cyc, e.addr, e.data, e.done, e.cyc);
        end
      end
    end else if (aDone) begin
      checks++;
      errors++;
      $display("[TB] FAIL doneA: frame_done=1 without write at cycle %0d, required 0", cyc);
    end
  end

  // Monitor for instance B: also checks outputs hold between spaced writes
  always @(negedge clock) begin
    if (bWrite) begin
      checks++;
      if (qB.size() == 0) begin
        errors++;
        $display("[TB] FAIL writeB: unexpected write addr=%0d data=%h cycle=%0d, required no write",
                 bAddr, bData, cyc);
      end else begin
        exp_t e;
        e = qB.pop_front();
        if (int'(bAddr) != e.addr || bData !== e.data || bDone !== e.done || cyc != e.cyc) begin
          errors++;
          $display("[TB] FAIL writeB: got addr=%0d data=%h done=%b cycle=%0d, required addr=%0d data=%h done=%b cycle=%0d",
                   bAddr, bData, bDone, cyc, e.addr, e.data, e.done, e.cyc);
        end
      end
      bLastAddr = bAddr;
      bLastData = bData;
      bHaveLast = 1'b1;
    end else if (bBusy && bHaveLast) begin
      checks++;
      if (bAddr !== bLastAddr || bData !== bLastData) begin
        errors++;
        $display("[TB] FAIL holdB: got addr=%0d data=%h, required addr=%0d data=%h",
                 bAddr, bData, bLastAddr, bLastData);
      end
    end
  end

  // Pulse start on one instance; returns the cycle count of the start edge
  task automatic applyStimulus(input bit useB, input logic [1:0] m, input logic [DW-1:0] c,
                               input logic ct, output int startCyc);
    mode  = m;
    color = c;
    cont  = ct;
    if (useB) bStart = 1'b1;
    else      aStart = 1'b1;
    @(posedge clock);
    #1;
    aStart   = 1'b0;
    bStart   = 1'b0;
    startCyc = cyc;
  endtask

  // Queue the expected writes of one frame (or its first count pixels)
  task automatic pushFrame(input bit useB, input logic [1:0] m, input logic [DW-1:0] c,
                           input int base, input int spacing, input int count);
    for (int i = 0; i < count; i++) begin
      exp_t e;
      e.addr = i;
      e.data = expPix(m, c, i % COLS, i / COLS);
      e.done = (i == NPIX - 1);
      e.cyc  = base + i * spacing;
      if (useB) qB.push_back(e);
      else      qA.push_back(e);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic waitIdle(input bit useB, input int budget);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < budget && !idle; i++) begin
      waitCycles(1);
      idle = useB ? !bBusy : !aBusy;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("[TB] FAIL waitIdle: busy=1 after %0d cycles, required 0", budget);
    end
  endtask

  initial begin
    int t;
    reset  = 1'b1;
    mode   = 2'd0;
    color  = '0;
    cont   = 1'b0;
    aStart = 1'b0;
    bStart = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    checkOutput("rstAddr", 32'(aAddr), 0);
    checkOutput("rstData", 32'(aData), 0);
    checkOutput("rstWrite", 32'(aWrite), 0);
    checkOutput("rstBusy", 32'(aBusy), 0);
    checkOutput("rstDone", 32'(aDone), 0);
    checkOutput("rstBusyB", 32'(bBusy), 0);
    reset = 1'b0;
    waitCycles(1);

    // Solid frame, back-to-back writes, done only on the last pixel
    applyStimulus(1'b0, 2'd0, 12'hA5C, 1'b0, t);
    pushFrame(1'b0, 2'd0, 12'hA5C, t, 1, NPIX);
    checkOutput("firstAddr", 32'(aAddr), 0);
    checkOutput("firstBusy", 32'(aBusy), 1);
    waitCycles(NPIX - 1);
    checkOutput("lastDone", 32'(aDone), 1);
    checkOutput("lastAddr", 32'(aAddr), NPIX - 1);
    waitCycles(1);
    checkOutput("endBusy", 32'(aBusy), 0);
    checkOutput("endWrite", 32'(aWrite), 0);

    // Checkerboard, gradient and line stripes
    applyStimulus(1'b0, 2'd2, 12'hF00, 1'b0, t);
    pushFrame(1'b0, 2'd2, 12'hF00, t, 1, NPIX);
    waitIdle(1'b0, 40);
    applyStimulus(1'b0, 2'd1, 12'h000, 1'b0, t);
    pushFrame(1'b0, 2'd1, 12'h000, t, 1, NPIX);
    waitIdle(1'b0, 40);
    applyStimulus(1'b0, 2'd3, 12'h000, 1'b0, t);
    pushFrame(1'b0, 2'd3, 12'h000, t, 1, NPIX);
    waitIdle(1'b0, 40);

    // Spaced writes on instance B: one write every three cycles
    applyStimulus(1'b1, 2'd1, 12'h000, 1'b0, t);
    pushFrame(1'b1, 2'd1, 12'h000, t, 3, NPIX);
    waitCycles(3 * (NPIX - 1));
    checkOutput("lastDoneB", 32'(bDone), 1);
    waitCycles(1);
    checkOutput("endBusyB", 32'(bBusy), 0);

    // Continuous run: mode change mid-frame 1 shows up in frame 2 only,
    // continuous dropped mid-frame 2 ends the run after frame 2
    applyStimulus(1'b0, 2'd0, 12'h123, 1'b1, t);
    pushFrame(1'b0, 2'd0, 12'h123, t, 1, NPIX);
    pushFrame(1'b0, 2'd2, 12'h456, t + NPIX, 1, NPIX);
    waitCycles(3);
    mode  = 2'd2;
    color = 12'h456;
    waitCycles(8);
    checkOutput("contLastAddr", 32'(aAddr), NPIX - 1);
    waitCycles(1);
    checkOutput("contWrapAddr", 32'(aAddr), 0);
    checkOutput("contWrapWrite", 32'(aWrite), 1);
    waitCycles(3);
    cont = 1'b0;
    waitCycles(8);
    checkOutput("contDone2", 32'(aDone), 1);
    waitCycles(1);
    checkOutput("contStopBusy", 32'(aBusy), 0);
    waitCycles(3);
    checkOutput("contStopWrite", 32'(aWrite), 0);

    // Start while busy is ignored
    applyStimulus(1'b0, 2'd0, 12'h0F0, 1'b0, t);
    pushFrame(1'b0, 2'd0, 12'h0F0, t, 1, NPIX);
    waitCycles(4);
    mode   = 2'd1;
    aStart = 1'b1;
    waitCycles(1);
    aStart = 1'b0;
    mode   = 2'd0;
    waitCycles(7);
    checkOutput("ignoreBusy", 32'(aBusy), 0);
    waitCycles(2);
    checkOutput("ignoreNoRestart", 32'(aBusy), 0);

    // Reset in the middle of a frame aborts it; a new start begins at 0
    applyStimulus(1'b0, 2'd0, 12'h777, 1'b0, t);
    pushFrame(1'b0, 2'd0, 12'h777, t, 1, 6);
    waitCycles(5);
    checkOutput("abortAddr", 32'(aAddr), 5);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("abortWrite", 32'(aWrite), 0);
    checkOutput("abortBusy", 32'(aBusy), 0);
    reset = 1'b0;
    waitCycles(3);
    applyStimulus(1'b0, 2'd1, 12'h000, 1'b0, t);
    pushFrame(1'b0, 2'd1, 12'h000, t, 1, NPIX);
    checkOutput("restartAddr", 32'(aAddr), 0);
    checkOutput("restartWrite", 32'(aWrite), 1);
    waitIdle(1'b0, 40);
    waitCycles(2);

    checkOutput("queueA", 32'(qA.size()), 0);
    checkOutput("queueB", 32'(qB.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
